// File: rtl/cam_pkg.sv
// Shared camera-path constants and the capture FSM state type.
package cam_pkg;
  localparam int IMG_W        = 320;
  localparam int IMG_H        = 240;
  localparam int PIX_W        = 8;
  localparam int ADDR_W       = 17;
  localparam int COORD_W      = 10;
  localparam int FRAME_PIXELS = IMG_W * IMG_H;
  localparam int SUM_W        = 25;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} cap_state_t;
endpackage

// File: rtl/cam_frame_capture_if.sv
// Camera pixel stream: one pixel with its raster coordinates, qualified by pix_valid.
interface cam_frame_capture_if #(
  parameter int PIX_W   = cam_pkg::PIX_W,
  parameter int COORD_W = cam_pkg::COORD_W
);
  logic [PIX_W-1:0]   pix_value;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_valid;

  modport master (output pix_value, pix_x, pix_y, pix_valid);
  modport slave  (input  pix_value, pix_x, pix_y, pix_valid);
endinterface

// File: rtl/cam_frame_ram.sv
// Frame store: one write port, one registered read port; out-of-range reads return 0.
module cam_frame_ram #(
  parameter int DEPTH  = cam_pkg::FRAME_PIXELS,
  parameter int PIX_W  = cam_pkg::PIX_W,
  parameter int ADDR_W = cam_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);
  localparam int RA = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[wr_addr[RA-1:0]] <= wr_data;

  // Read and write on the same edge: the read sees the old contents.
  always_ff @(posedge clk) begin
    if (reset)                rd_data <= '0;
    else if (rd_addr < LIMIT) rd_data <= mem[rd_addr[RA-1:0]];
    else                      rd_data <= '0;
  end
endmodule

// File: rtl/cam_frame_capture.sv
// Captures one raster-checked frame per arm into the frame RAM.
// Optional CAM_CAP_CHECKSUM_EN adds frame_sum, the pixel sum of the last completed frame.
module cam_frame_capture #(
  parameter int IMG_W  = cam_pkg::IMG_W,
  parameter int IMG_H  = cam_pkg::IMG_H,
  parameter int PIX_W  = cam_pkg::PIX_W,
  parameter int ADDR_W = cam_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  cam_frame_capture_if.slave  pix,
  input  logic                arm,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [PIX_W-1:0]    rd_data,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_err
`ifdef CAM_CAP_CHECKSUM_EN
  , output logic [cam_pkg::SUM_W-1:0] frame_sum
`endif
);
  import cam_pkg::*;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
  localparam logic [ADDR_W-1:0]  A_ONE  = ADDR_W'(1);

  cap_state_t         state;
  logic [COORD_W-1:0] exp_x, exp_y;
  logic [ADDR_W-1:0]  wr_addr;
  logic               sof, hit, last, we;

  // exp_x/exp_y never leave the frame, so out-of-range coordinates always miss.
  assign sof  = pix.pix_valid && (pix.pix_x == '0) && (pix.pix_y == '0);
  assign hit  = pix.pix_valid && (pix.pix_x == exp_x) && (pix.pix_y == exp_y);
  assign last = (exp_x == X_LAST) && (exp_y == Y_LAST);
  assign we   = !reset && (((state == ARMED) && sof) || ((state == CAPTURE) && hit));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      exp_x      <= '0;
      exp_y      <= '0;
      wr_addr    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: if (arm) begin
          state     <= ARMED;
          busy      <= 1'b1;
          frame_err <= 1'b0;
          wr_addr   <= '0;
        end
        ARMED: if (sof) begin
          state   <= CAPTURE;
          exp_x   <= C_ONE;
          exp_y   <= '0;
          wr_addr <= A_ONE;
        end
        CAPTURE: if (pix.pix_valid) begin
          if (hit) begin
            wr_addr <= wr_addr + A_ONE;
            if (exp_x == X_LAST) begin
              exp_x <= '0;
              exp_y <= exp_y + C_ONE;
            end else begin
              exp_x <= exp_x + C_ONE;
            end
            if (last) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end else begin
            state     <= ARMED;
            frame_err <= 1'b1;
            wr_addr   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CAM_CAP_CHECKSUM_EN
  logic [SUM_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      frame_sum <= '0;
    end else if ((state == ARMED) && sof) begin
      acc <= SUM_W'(pix.pix_value);
    end else if ((state == CAPTURE) && pix.pix_valid) begin
      if (hit) begin
        acc <= acc + SUM_W'(pix.pix_value);
        if (last) frame_sum <= acc + SUM_W'(pix.pix_value);
      end else begin
        acc <= '0;
      end
    end
  end
`endif

  cam_frame_ram #(
    .DEPTH (IMG_W * IMG_H),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(pix.pix_value),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture on a reduced 16x8 frame geometry.
module tb_cam_frame_capture;
  localparam int W    = 16;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic [16:0] rd_addr;
  logic [7:0]  rd_data;
  logic        busy, frame_done, frame_err;
`ifdef CAM_CAP_CHECKSUM_EN
  logic [24:0] frame_sum;
`endif

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  cam_frame_capture_if pif ();

  cam_frame_capture #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix       (pif),
    .arm       (arm),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err)
`ifdef CAM_CAP_CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  function automatic logic [7:0] pat(input int seed, input int a);
    return 8'((a + seed) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    pif.pix_valid = 1'b0;
    pif.pix_x     = 10'd999;
    pif.pix_y     = 10'd999;
    pif.pix_value = 8'hA5;
  endtask

  task automatic send_pix(input int x, input int y, input logic [7:0] v);
    pif.pix_valid = 1'b1;
    pif.pix_x     = 10'(x);
    pif.pix_y     = 10'(y);
    pif.pix_value = v;
    tick();
    idle_bus();
  endtask

  task automatic stream(input int seed, input int from, input int to, input int gap, input int skip);
    for (int a = from; a <= to; a++) begin
      if (a != skip) begin
        send_pix(a % W, a / W, pat(seed, a));
        repeat (gap) tick();
      end
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    rd_addr = 17'(a);
    tick();
    d = rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; rd_addr = '0; idle_bus();
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
`ifdef CAM_CAP_CHECKSUM_EN
    checks++; if (frame_sum !== 25'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", frame_sum); end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    logic [7:0] d;
    int addrs[5] = '{0, 1, 17, 64, NPIX - 1};
    do_arm();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy_after_arm: got %b want 1", busy); end
    stream(0, 0, NPIX - 2, 1, -1);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL ramp_early_done: got %0d want 0", done_cnt); end
    send_pix(W - 1, H - 1, pat(0, NPIX - 1));
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL ramp_done_pulse: got %b want 1", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_end: got %b want 0", busy); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ramp_done_width: got %b want 0", frame_done); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ramp_done_count: got %0d want 1", done_cnt); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ramp_err: got %b want 0", frame_err); end
    foreach (addrs[i]) begin
      rd(addrs[i], d);
      checks++; if (d !== pat(0, addrs[i])) begin errors++; $display("FAIL ramp_ram[%0d]: got %h want %h", addrs[i], d, pat(0, addrs[i])); end
    end
  endtask

  task automatic test_mid_frame_arm();
    logic [7:0] d;
    int d0 = done_cnt;
    do_arm();
    stream(50, 4 * W, NPIX - 1, 0, -1);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midarm_no_done: got %0d want %0d", done_cnt, d0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midarm_busy: got %b want 1", busy); end
    rd(70, d);
    checks++; if (d !== pat(0, 70)) begin errors++; $display("FAIL midarm_no_write: got %h want %h", d, pat(0, 70)); end
    stream(9, 0, NPIX - 1, 0, -1);
    tick();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL midarm_done: got %0d want %0d", done_cnt, d0 + 1); end
    rd(0, d);
    checks++; if (d !== pat(9, 0)) begin errors++; $display("FAIL midarm_sof_pixel: got %h want %h", d, pat(9, 0)); end
    rd(100, d);
    checks++; if (d !== pat(9, 100)) begin errors++; $display("FAIL midarm_ram100: got %h want %h", d, pat(9, 100)); end
  endtask

  task automatic test_drop_pixel();
    logic [7:0] d;
    int d0 = done_cnt;
    do_arm();
    stream(20, 0, NPIX - 1, 0, 3 * W + 5);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL drop_err: got %b want 1", frame_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b want 1", busy); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL drop_no_done: got %0d want %0d", done_cnt, d0); end
    stream(30, 0, NPIX - 1, 0, -1);
    tick();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL drop_resync_done: got %0d want %0d", done_cnt, d0 + 1); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL drop_err_sticky: got %b want 1", frame_err); end
    rd(3 * W + 5, d);
    checks++; if (d !== pat(30, 3 * W + 5)) begin errors++; $display("FAIL drop_ram53: got %h want %h", d, pat(30, 3 * W + 5)); end
    do_arm();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL drop_err_cleared: got %b want 0", frame_err); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d;
    send_pix(0, 0, pat(77, 0));
    send_pix(1, 0, pat(77, 1));
    send_pix(W, 0, 8'hEE);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", frame_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oor_busy: got %b want 1", busy); end
    rd(2, d);
    checks++; if (d !== pat(30, 2)) begin errors++; $display("FAIL oor_no_write: got %h want %h", d, pat(30, 2)); end
  endtask

  task automatic test_reset_mid_capture();
    logic [7:0] d;
    int addrs[4] = '{0, 59, 60, 61};
    logic [7:0] want[4];
    want = '{pat(40, 0), pat(40, 59), pat(30, 60), pat(30, 61)};
    stream(40, 0, 59, 0, -1);
    pif.pix_valid = 1'b1; pif.pix_x = 10'(60 % W); pif.pix_y = 10'(60 / W); pif.pix_value = pat(40, 60);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_bus();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", frame_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", frame_err); end
    stream(40, 61, 63, 0, -1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b want 0", busy); end
    foreach (addrs[i]) begin
      rd(addrs[i], d);
      checks++; if (d !== want[i]) begin errors++; $display("FAIL rst_mid_ram[%0d]: got %h want %h", addrs[i], d, want[i]); end
    end
  endtask

  task automatic test_read_port();
    logic [7:0] d;
    int oor[3] = '{NPIX, 76800, 131071};
    rd(6, d);
    rd_addr = 17'd5;
    #1;
    checks++; if (rd_data !== pat(40, 6)) begin errors++; $display("FAIL rd_latency_hold: got %h want %h", rd_data, pat(40, 6)); end
    tick();
    checks++; if (rd_data !== pat(40, 5)) begin errors++; $display("FAIL rd_addr5: got %h want %h", rd_data, pat(40, 5)); end
    foreach (oor[i]) begin
      rd(oor[i], d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rd_oor[%0d]: got %h want 00", oor[i], d); end
      rd(5, d);
    end
  endtask

`ifdef CAM_CAP_CHECKSUM_EN
  task automatic test_checksum();
    do_arm();
    for (int a = 0; a < NPIX; a++) send_pix(a % W, a / W, 8'hFF);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL sum_done: got %b want 1", frame_done); end
    checks++; if (frame_sum !== 25'(NPIX * 255)) begin errors++; $display("FAIL sum_value: got %0d want %0d", frame_sum, NPIX * 255); end
    repeat (4) tick();
    checks++; if (frame_sum !== 25'(NPIX * 255)) begin errors++; $display("FAIL sum_hold: got %0d want %0d", frame_sum, NPIX * 255); end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_mid_frame_arm();
    test_drop_pixel();
    test_out_of_range();
    test_reset_mid_capture();
    test_read_port();
`ifdef CAM_CAP_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
